int_div_unit: RTL

INT_DIV_UNIT -- requirements
Module: int_div_unit

---
 rtl/int_div_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/int_div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU): radix-2 restoring, one bit per cycle.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow directly from IDLE.
module int_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]      count_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] rs1_q;
  logic [4:0]      rd_q;
  logic            is_rem_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            dz_q;
  logic            ovf_q;

  // Operand preparation in IDLE
  logic            op_signed;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            dz_in;
  logic            ovf_in;
  logic            fast_special;
  logic            accept;

  assign op_signed = ~op_i[0];
  assign abs_a     = (op_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign abs_b     = (op_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
  assign dz_in     = (rs2_i == '0);
  assign ovf_in    = op_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign accept    = (state_q == IDLE) && start_i && !flush_i;

`ifdef DIV_FAST_SPECIAL_EN
  assign fast_special = dz_in || ovf_in;
`else
  assign fast_special = 1'b0;
`endif

  // One restoring step; the extra top bit makes the subtract's borrow visible
  logic [XLEN+1:0] rem_sh;
  logic [XLEN+1:0] diff;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {2'b00, div_q};
    if (!diff[XLEN+1]) begin
      rem_nxt = diff[XLEN:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] final_res;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = fast_special ? DONE : CALC;
      CALC:    if (count_q == 5'd31) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;

    q_fix = neg_q_q ? -quo_q : quo_q;
    r_fix = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (dz_q) begin
      final_res = is_rem_q ? rs1_q : '1;
    end else if (ovf_q) begin
      final_res = is_rem_q ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      final_res = is_rem_q ? r_fix : q_fix;
    end

    busy_o   = (state_q != IDLE);
    valid_o  = (state_q == DONE);
    result_o = '0;
    rd_o     = '0;
    if (state_q == DONE) begin
      result_o = final_res;
      rd_o     = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= abs_a;
      div_q    <= abs_b;
      rs1_q    <= rs1_i;
      rd_q     <= rd_i;
      is_rem_q <= op_i[1];
      neg_q_q  <= op_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
      neg_r_q  <= op_signed && rs1_i[XLEN-1];
      dz_q     <= dz_in;
      ovf_q    <= ovf_in;
    end else if (state_q == CALC) begin
      count_q <= count_q + 5'd1;
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
    end
  end

endmodule
